// File: rtl/axi_traffic_gen.sv
// AXI write-then-readback traffic generator for one mesh slave port.
// Ports: aclk/aresetn, m_axi_o/m_axi_i, start+config, busy/done/timeout, err_count, bursts_done.
package axi_traffic_gen_pkg;
  localparam int AXI_ID_W   = 5;
  localparam int AXI_ADDR_W = 16;
  localparam int AXI_DATA_W = 8;

  typedef struct packed {
    logic                    awvalid;
    logic [AXI_ID_W-1:0]     awid;
    logic [AXI_ADDR_W-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    wvalid;
    logic [AXI_DATA_W-1:0]   wdata;
    logic [AXI_DATA_W/8-1:0] wstrb;
    logic                    wlast;
    logic                    bready;
    logic                    arvalid;
    logic [AXI_ID_W-1:0]     arid;
    logic [AXI_ADDR_W-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    rready;
  } axi_mosi_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic                  bvalid;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  arready;
    logic                  rvalid;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
  } axi_miso_t;
endpackage

module axi_traffic_gen
  import axi_traffic_gen_pkg::*;
#(
  parameter int ID_WIDTH       = AXI_ID_W,
  parameter int ADDR_WIDTH     = AXI_ADDR_W,
  parameter int DATA_WIDTH     = AXI_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  output axi_mosi_t             m_axi_o,
  input  axi_miso_t             m_axi_i,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            burst_len,
  input  logic [15:0]           num_bursts,
  input  logic [ID_WIDTH-1:0]   txn_id,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [15:0]           bursts_done
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [15:0]           nb_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [7:0]            beat_q;
  logic [15:0]           n_q;
  logic [15:0]           err_q;
  logic [15:0]           bd_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  to_q;
  logic [WDW-1:0]        wd_q;

  logic                  accept;
  logic                  waiting;
  logic                  hs;
  logic                  wd_hit;
  logic                  last_beat;
  logic                  more;
  logic [DATA_WIDTH-1:0] pat;
  logic [1:0]            err_inc;
  logic [16:0]           err_sum;
  logic                  unused_rresp;

  assign unused_rresp = ^m_axi_i.rresp;

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign waiting   = state inside {S_AW, S_W, S_B, S_AR, S_R};
  assign last_beat = (beat_q == len_q);
  assign more      = ({1'b0, n_q} + 17'd1) < {1'b0, nb_q};
  assign pat       = seed_q + DATA_WIDTH'(addr_q[7:0] + beat_q);

  always_comb begin
    hs = 1'b0;
    unique case (state)
      S_AW:    hs = m_axi_i.awready;
      S_W:     hs = m_axi_i.wready;
      S_B:     hs = m_axi_i.bvalid;
      S_AR:    hs = m_axi_i.arready;
      S_R:     hs = m_axi_i.rvalid;
      default: hs = 1'b0;
    endcase
  end

  assign wd_hit = waiting && !hs &&
                  (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (start)
          state_nx = (num_bursts == '0) ? S_DONE : S_AW;
      end
      S_AW: if (hs) state_nx = S_W;
      S_W:  if (hs && last_beat) state_nx = S_B;
      S_B:  if (hs) state_nx = S_AR;
      S_AR: if (hs) state_nx = S_R;
      S_R:
        if (hs && m_axi_i.rlast)
          state_nx = more ? S_AW : S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (wd_hit) state_nx = S_DONE;
  end

  always_comb begin
    m_axi_o = '0;
    unique case (state)
      S_AW: begin
        m_axi_o.awvalid = 1'b1;
        m_axi_o.awid    = id_q;
        m_axi_o.awaddr  = addr_q;
        m_axi_o.awlen   = len_q;
        m_axi_o.awburst = 2'b01;
      end
      S_W: begin
        m_axi_o.wvalid = 1'b1;
        m_axi_o.wdata  = pat;
        m_axi_o.wstrb  = '1;
        m_axi_o.wlast  = last_beat;
      end
      S_B: m_axi_o.bready = 1'b1;
      S_AR: begin
        m_axi_o.arvalid = 1'b1;
        m_axi_o.arid    = id_q;
        m_axi_o.araddr  = addr_q;
        m_axi_o.arlen   = len_q;
        m_axi_o.arburst = 2'b01;
      end
      S_R: m_axi_o.rready = 1'b1;
      default: m_axi_o = '0;
    endcase
  end

  // A short RLAST beat that also carries bad data costs two.
  always_comb begin
    err_inc = 2'd0;
    if (state == S_B && m_axi_i.bvalid &&
        (m_axi_i.bid != id_q || m_axi_i.bresp != 2'b00))
      err_inc = 2'd1;
    if (state == S_R && m_axi_i.rvalid) begin
      if (m_axi_i.rdata != pat || m_axi_i.rid != id_q)
        err_inc = err_inc + 2'd1;
      if (m_axi_i.rlast && !last_beat)
        err_inc = err_inc + 2'd1;
    end
  end

  assign err_sum = {1'b0, err_q} + 17'(err_inc);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= S_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      nb_q   <= '0;
      id_q   <= '0;
      seed_q <= '0;
      beat_q <= '0;
      n_q    <= '0;
      err_q  <= '0;
      bd_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
      wd_q   <= '0;
    end else begin
      state <= state_nx;
      if (waiting && !hs) wd_q <= wd_q + WDW'(1);
      else                wd_q <= '0;
      if (wd_hit) to_q <= 1'b1;
      err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (state inside {S_AW, S_AR} && hs)
        beat_q <= '0;
      if (state == S_W && hs)
        beat_q <= beat_q + 8'd1;
      if (state == S_R && hs) begin
        beat_q <= beat_q + 8'd1;
        if (m_axi_i.rlast) begin
          beat_q <= '0;
          n_q    <= n_q + 16'd1;
          bd_q   <= bd_q + 16'd1;
          addr_q <= addr_q + ADDR_WIDTH'(len_q)
                    + ADDR_WIDTH'(1);
        end
      end
      if (accept) begin
        addr_q <= base_addr;
        len_q  <= burst_len;
        nb_q   <= num_bursts;
        id_q   <= txn_id;
        seed_q <= seed;
        beat_q <= '0;
        n_q    <= '0;
        err_q  <= '0;
        bd_q   <= '0;
        busy_q <= 1'b1;
        done_q <= 1'b0;
        to_q   <= 1'b0;
        wd_q   <= '0;
      end
      if (state_nx == S_DONE) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = to_q;
  assign err_count   = err_q;
  assign bursts_done = bd_q;

endmodule

// File: doc/axi_traffic_gen.md
Name: axi_traffic_gen

Overview:
- AXI initiator that drives one mesh slave port: write bursts, then read-back of each burst, with a check of the returned data against a deterministic pattern.
- One instance per mesh slave port. It replaces the externally driven stimulus in mesh throughput and integrity benches, with the PMU monitoring the same mosi/miso pair.
- Issues strictly one transaction at a time: AW, W, B, AR, R per burst.

Parameters:
- ID_WIDTH, 5, width of AWID/ARID/BID/RID.
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 8, data bus width; one beat is one byte (AxSIZE=0).
- TIMEOUT_CYCLES, 1024, cycles without a handshake in a waiting state before abort.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- m_axi_o  out  axi_mosi_t  AXI master request channels (AW, W, AR, BREADY, RREADY).
- m_axi_i  in  axi_miso_t  AXI responses (AWREADY, WREADY, B, ARREADY, R).
- start  in  1  pulse; config sampled when idle.
- base_addr  in  ADDR_WIDTH  address of the first burst.
- burst_len  in  8  AxLEN (beats-1).
- num_bursts  in  16  number of write+read burst pairs.
- txn_id  in  ID_WIDTH  ID used on AW and AR.
- seed  in  DATA_WIDTH  data pattern offset.
- busy  out  1  sequence in progress.
- done  out  1  level; sequence finished, held until the next accepted start.
- timeout  out  1  sequence aborted by the watchdog.
- err_count  out  16  data/ID/RLAST/response mismatches, saturating.
- bursts_done  out  16  completed write+read pairs.

Behaviour:
- Reset (async assert, sync release): every VALID and READY output is 0, payload fields are 0, state IDLE, busy=done=timeout=0, counters 0.
- Fixed fields: AxSIZE=0, AxBURST=INCR (2'b01), WSTRB=1.
- Burst address: burst n starts at A_n = base_addr + n*(burst_len+1), mod 2^ADDR_WIDTH (wraps).
- Beat pattern: beat k of burst n carries (seed + (A_n+k)[7:0]) mod 256.
- States: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - start=1 latches all config, clears err_count, bursts_done, done and timeout, sets busy.
  - If num_bursts=0, go to DONE; otherwise go to AW, with AWVALID high the cycle after start.
- AW: AWVALID=1, AWID=txn_id, AWADDR=A_n, AWLEN=burst_len. Payload stable while AWVALID&!AWREADY. On handshake go to W.
- W:
  - WVALID=1 with beat data; advance the beat on WREADY.
  - WLAST=1 only on beat burst_len.
  - After the WLAST handshake go to B. WVALID stays low until W is entered (no early W).
- B:
  - BREADY=1; one response accepted, then go to AR.
  - BID != txn_id or BRESP != OKAY: err_count+1.
- AR: mirrors AW using ARID/ARADDR/ARLEN; on handshake go to R.
- R:
  - RREADY=1.
  - Each accepted beat is compared with the pattern: mismatch of RDATA or RID adds err_count+1 per beat.
  - The burst ends on an accepted RLAST; if the RLAST beat index != burst_len, err_count+1.
  - Then bursts_done+1, n+1. Go to AW if n < num_bursts, else DONE.
- DONE: busy=0, done=1, all VALID/READY low. Return to IDLE combinationally so the next start is accepted; done stays high until then.
- start while busy is ignored.
- err_count saturates at 16'hFFFF.
- Watchdog:
  - The counter resets on every handshake and on state entry.
  - In AW/W/B/AR/R it increments each cycle. Reaching TIMEOUT_CYCLES sets timeout=1, forces DONE next cycle and drops all VALID/READY.
  - A dropped VALID without a handshake is permitted only in this abort case.
- Reset mid-operation: outputs return to reset values immediately (async). No transaction is resumed.

Test Plan:
- Basic write/read: base 0x0100, len 3, bursts 1, seed 0x5A, id 0x07, all ready high -> AWADDR 0x0100 AWLEN 3, W data 0x5A,0x5B,0x5C,0x5D with WLAST on the 4th, BID 0x07 accepted, AR 0x0100, done=1, err_count=0, bursts_done=1.
- Backpressure: hold AWREADY low 5 cycles, then WREADY toggling every cycle -> AWVALID/AWADDR stable for 5 cycles, W beats neither repeated nor skipped, completes with err_count=0.
- Corruption: responder flips RDATA beat 2 and returns RLAST on beat 2 with len 3 -> err_count=2, done=1.
- Wrap: base 0xFFFE, len 3, bursts 2 -> second AWADDR/ARADDR 0x0002, beat data follows the wrapped address low byte.
- Zero bursts and busy: num_bursts=0 -> done=1 one cycle after start, no VALID asserted. A start pulse while busy leaves the latched config unchanged.
- Timeout/reset: AWREADY held low for 1024 cycles -> timeout=1, done=1, AWVALID low. In a separate run, aresetn asserted mid-W -> WVALID low the same cycle, busy=0.
